// File: rtl/dma_pkg.sv
// Shared types and constants for the ICB block-copy DMA master.
package dma_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_CMD,
        ST_RD_RSP,
        ST_WR_CMD,
        ST_WR_RSP,
        ST_FIN
    } dma_state_t;

    localparam logic [3:0]  WMASK_FULL = 4'hF;
    localparam int unsigned WORD_BYTES = 4;

endpackage

// File: rtl/icb_master_port.sv
// ICB command/response holder: registered valid, payload held until accepted,
// response acceptance window and read-data capture (the word buffer).
module icb_master_port
    import dma_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              issue,
    input  logic              issue_read,
    input  logic [ADDR_W-1:0] issue_addr,
    output logic              cmd_fire,
    output logic              rsp_fire,
    output logic              icb_cmd_valid,
    input  logic              icb_cmd_ready,
    output logic              icb_cmd_read,
    output logic [ADDR_W-1:0] icb_cmd_addr,
    output logic [31:0]       icb_cmd_wdata,
    output logic [3:0]        icb_cmd_wmask,
    input  logic              icb_rsp_valid,
    output logic              icb_rsp_ready,
    input  logic [31:0]       icb_rsp_rdata
);

    logic              valid_q, valid_d;
    logic              read_q, read_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        wmask_q, wmask_d;
    logic [31:0]       data_q, data_d;
    logic              rsp_ready_q, rsp_ready_d;

    always_comb begin
        cmd_fire    = valid_q & icb_cmd_ready;
        rsp_fire    = rsp_ready_q & icb_rsp_valid;
        valid_d     = valid_q;
        read_d      = read_q;
        addr_d      = addr_q;
        wmask_d     = wmask_q;
        data_d      = data_q;
        rsp_ready_d = rsp_ready_q;

        if (cmd_fire) begin
            valid_d = 1'b0;
        end
        // Payload only loads on a new issue, so it cannot move while waiting for ready.
        if (issue) begin
            valid_d = 1'b1;
            read_d  = issue_read;
            addr_d  = issue_addr;
            wmask_d = issue_read ? 4'h0 : WMASK_FULL;
        end

        if (cmd_fire) begin
            rsp_ready_d = 1'b1;
        end else if (rsp_fire) begin
            rsp_ready_d = 1'b0;
        end

        if (rsp_fire && read_q) begin
            data_d = icb_rsp_rdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= 1'b0;
            read_q      <= 1'b0;
            addr_q      <= '0;
            wmask_q     <= '0;
            data_q      <= '0;
            rsp_ready_q <= 1'b0;
        end else begin
            valid_q     <= valid_d;
            read_q      <= read_d;
            addr_q      <= addr_d;
            wmask_q     <= wmask_d;
            data_q      <= data_d;
            rsp_ready_q <= rsp_ready_d;
        end
    end

    assign icb_cmd_valid = valid_q;
    assign icb_cmd_read  = read_q;
    assign icb_cmd_addr  = addr_q;
    assign icb_cmd_wdata = data_q;
    assign icb_cmd_wmask = wmask_q;
    assign icb_rsp_ready = rsp_ready_q;

endmodule

// File: rtl/icb_dma_master.sv
// Word-copy DMA master: one outstanding ICB transaction, read then write per word,
// done pulse at the end and a sticky error flag.
module icb_dma_master
    import dma_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned LEN_W  = 13
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  len_words,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              icb_cmd_valid,
    input  logic              icb_cmd_ready,
    output logic              icb_cmd_read,
    output logic [ADDR_W-1:0] icb_cmd_addr,
    output logic [31:0]       icb_cmd_wdata,
    output logic [3:0]        icb_cmd_wmask,
    input  logic              icb_rsp_valid,
    output logic              icb_rsp_ready,
    input  logic [31:0]       icb_rsp_rdata,
    input  logic              icb_rsp_err
);

    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(WORD_BYTES);

    dma_state_t        state_q, state_d;
    logic [ADDR_W-1:0] src_q, src_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic              err_q, err_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;

    logic              issue, issue_read, cmd_fire, rsp_fire;
    logic [ADDR_W-1:0] issue_addr;

    always_comb begin
        state_d    = state_q;
        src_d      = src_q;
        dst_d      = dst_q;
        rem_d      = rem_q;
        err_d      = err_q;
        issue      = 1'b0;
        issue_read = 1'b0;
        issue_addr = '0;

        // Commands are issued on the transition into a CMD state so valid is registered.
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    src_d = {src_addr[ADDR_W-1:2], 2'b00};
                    dst_d = {dst_addr[ADDR_W-1:2], 2'b00};
                    rem_d = len_words;
                    err_d = 1'b0;
                    if (len_words == '0) begin
                        state_d = ST_FIN;
                    end else begin
                        state_d    = ST_RD_CMD;
                        issue      = 1'b1;
                        issue_read = 1'b1;
                        issue_addr = src_d;
                    end
                end
            end
            ST_RD_CMD: if (cmd_fire) state_d = ST_RD_RSP;
            ST_RD_RSP: begin
                if (rsp_fire) begin
                    if (icb_rsp_err) begin
                        err_d   = 1'b1;
                        state_d = ST_FIN;
                    end else begin
                        state_d    = ST_WR_CMD;
                        issue      = 1'b1;
                        issue_addr = dst_q;
                    end
                end
            end
            ST_WR_CMD: if (cmd_fire) state_d = ST_WR_RSP;
            ST_WR_RSP: begin
                if (rsp_fire) begin
                    src_d = src_q + STEP;
                    dst_d = dst_q + STEP;
                    rem_d = rem_q - 1'b1;
                    if (icb_rsp_err) begin
                        err_d   = 1'b1;
                        state_d = ST_FIN;
                    end else if (rem_q == LEN_W'(1)) begin
                        state_d = ST_FIN;
                    end else begin
                        state_d    = ST_RD_CMD;
                        issue      = 1'b1;
                        issue_read = 1'b1;
                        issue_addr = src_d;
                    end
                end
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_FIN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            rem_q   <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            rem_q   <= rem_d;
            err_q   <= err_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign err  = err_q;

    icb_master_port #(
        .ADDR_W(ADDR_W)
    ) u_port (
        .clk           (clk),
        .rst_n         (rst_n),
        .issue         (issue),
        .issue_read    (issue_read),
        .issue_addr    (issue_addr),
        .cmd_fire      (cmd_fire),
        .rsp_fire      (rsp_fire),
        .icb_cmd_valid (icb_cmd_valid),
        .icb_cmd_ready (icb_cmd_ready),
        .icb_cmd_read  (icb_cmd_read),
        .icb_cmd_addr  (icb_cmd_addr),
        .icb_cmd_wdata (icb_cmd_wdata),
        .icb_cmd_wmask (icb_cmd_wmask),
        .icb_rsp_valid (icb_rsp_valid),
        .icb_rsp_ready (icb_rsp_ready),
        .icb_rsp_rdata (icb_rsp_rdata)
    );

endmodule

// File: doc/icb_dma_master.md
Name: icb_dma_master

Overview:
ICB initiator that copies a block of 32-bit words from a source address to a destination address over one ICB master port. It is the bus master that loads ifmap/weight words into the accelerator input SRAM and drains ofmap words from the output SRAM, replacing CPU word-by-word stores. It is programmed by a start pulse plus src/dst/length, keeps one transaction outstanding at a time, and pulses done when finished.

Parameters:
ADDR_W, 32, ICB address width
LEN_W, 13, word-count width (up to 8191 words, one 8k SRAM)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle request; sampled only in IDLE
src_addr  in  ADDR_W  source byte address; bits [1:0] forced to 0
dst_addr  in  ADDR_W  destination byte address; bits [1:0] forced to 0
len_words  in  LEN_W  number of words to copy
busy  out  1  high whenever the state is not IDLE
done  out  1  one-cycle pulse at the end of a transfer
err  out  1  sticky error; cleared by the next accepted start
icb_cmd_valid  out  1  command valid
icb_cmd_ready  in  1  command accepted
icb_cmd_read  out  1  1 = read, 0 = write
icb_cmd_addr  out  32  command address
icb_cmd_wdata  out  32  write data
icb_cmd_wmask  out  4  byte mask; always 4'hF on writes, 4'h0 on reads
icb_rsp_valid  in  1  response valid
icb_rsp_ready  out  1  response accept
icb_rsp_rdata  in  32  read data
icb_rsp_err  in  1  response error

Behaviour:
- Reset: all outputs 0; state IDLE; internal address, count and data registers 0.
- States: IDLE, RD_CMD, RD_RSP, WR_CMD, WR_RSP, FIN.
- IDLE, start=1:
  - Latch src/dst with [1:0] cleared, latch len into remaining, clear err.
  - If len=0, go to FIN with no bus activity.
  - Otherwise go to RD_CMD.
  - start in any other state is ignored.
- RD_CMD:
  - Drive icb_cmd_valid=1, read=1, addr=src_ptr.
  - On valid&ready, go to RD_RSP.
  - valid, addr and read stay stable until the handshake.
- RD_RSP:
  - Drive icb_rsp_ready=1.
  - On rsp_valid, capture rdata into data_buf and go to WR_CMD.
  - If rsp_err=1, set err and go to FIN without writing.
- WR_CMD:
  - Drive valid=1, read=0, addr=dst_ptr, wdata=data_buf, wmask=4'hF.
  - On handshake, go to WR_RSP.
- WR_RSP:
  - Drive rsp_ready=1.
  - On rsp_valid: src_ptr+=4, dst_ptr+=4, remaining-=1.
  - If rsp_err, set err and go to FIN.
  - Else if remaining==1 (the last word), go to FIN.
  - Else go to RD_CMD.
- FIN: done=1 for exactly one cycle; next state IDLE; busy=0 on the following cycle.
- icb_rsp_ready=0 outside RD_RSP/WR_RSP. A rsp_valid arriving outside those states is ignored (protocol violation, flagged by an assertion in the bench).
- Pointers wrap modulo 2^ADDR_W with no error.
- icb_cmd_valid is registered. Minimum cost is 4 cycles per word (ready high, response the cycle after the command), plus 1 start cycle and 1 FIN cycle.
- Responses may stall arbitrarily long; there is no timeout.
- Reset mid-transfer aborts immediately: no done pulse, bus outputs drop to 0 asynchronously.

Decomposition:
- Shared package dma_pkg:
  - state enum dma_state_t;
  - WMASK_FULL=4'hF;
  - WORD_BYTES=4.
- Sub-module icb_master_port: the cmd/rsp handshake holder (registered valid, stable payload, rsp capture). The top FSM sequences it through read and write phases.

Test Plan:
- Single word: src=0x0, dst=0x1000_3FC0, len=1, slave ready always, rsp the next cycle. Expect:
  - read 0x0, then write 0x1000_3FC0 with the returned data 0xDEAD_BEEF, wmask F;
  - done 6 cycles after start;
  - err=0.
- Burst with backpressure: len=9 (a weight block), cmd_ready low 3 cycles on every 2nd command, rsp delayed 0–5 cycles at random. Expect:
  - 9 reads at src+0..+32 and 9 writes in order;
  - payload stable while valid&!ready;
  - exactly one done.
- Error abort: rsp_err=1 on the 3rd read of a len=5 transfer. Expect:
  - 2 writes only;
  - err=1, done pulse;
  - the next start clears err.
- Zero length and start while busy: len=0 gives done 2 cycles after start with no icb_cmd_valid. A second start while busy is ignored, and the original transfer completes unchanged.
- Alignment and wrap: src=0x0000_0003 with len=2 reads 0x0 and 0x4. dst=0xFFFF_FFFC with len=2 writes 0xFFFF_FFFC and then 0x0000_0000.
- Reset mid-transfer: assert rst_n low during WR_CMD. Expect:
  - all outputs 0 immediately, no done;
  - a fresh start afterwards runs normally.
